// File: rtl/fwd_ctrl_gen.sv
// fwd_ctrl_gen: ID-stage forwarding control.
// Keeps a shadow copy of the destination register, write enable and load flag
// of each instruction in EX, MM1, MM2 and WB. From that copy it drives the
// operand forwarding selects and the load-use stall.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_valid, id_rj/rk, id_rj/rk_used   ID instruction and its source operands
//   id_rd, id_gr_we, id_is_load     ID instruction destination info
//   id_adv..wb_adv                  per-stage advance strobes
//   flush                           drop every in-flight entry
//   fwd_rj, fwd_rk                  forwarding selects (combinational)
//   id_stall                        ID must not advance (combinational)
module fwd_ctrl_gen #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NSTG   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rj,
    input  logic [REG_AW-1:0] id_rk,
    input  logic              id_rj_used,
    input  logic              id_rk_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_gr_we,
    input  logic              id_is_load,
    input  logic              id_adv,
    input  logic              ex_adv,
    input  logic              mm1_adv,
    input  logic              mm2_adv,
    input  logic              wb_adv,
    input  logic              flush,
    output logic [2:0]        fwd_rj,
    output logic [2:0]        fwd_rk,
    output logic              id_stall
);

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] FWD_GR      = 3'd0;
    localparam logic [SEL_W-1:0] FWD_EX      = 3'd1;
    localparam logic [SEL_W-1:0] FWD_MM1     = 3'd2;
    localparam logic [SEL_W-1:0] FWD_MM2_REG = 3'd3;
    localparam logic [SEL_W-1:0] FWD_MM2_MEM = 3'd4;
    localparam logic [SEL_W-1:0] FWD_WB      = 3'd5;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } ent_t;

    // Index 0 = EX, 1 = MM1, 2 = MM2, 3 = WB.
    ent_t stg_q [NSTG];
    ent_t stg_d [NSTG];

    logic [NSTG-1:0]             adv;
    logic [NSTG-1:0]             v_vec;
    logic [NSTG-1:0]             we_vec;
    logic [NSTG-1:0]             ld_vec;
    logic [NSTG-1:0][REG_AW-1:0] rd_vec;
    logic [SEL_W:0]              res_rj;
    logic [SEL_W:0]              res_rk;
    logic                        cap;

    // Advance-out strobe of each tracked stage.
    assign adv = NSTG'({wb_adv, mm2_adv, mm1_adv, ex_adv});

    // Returns {hazard, select}. Walks oldest to youngest so the youngest hit
    // has the final say; a younger load hazard therefore masks older hits.
    function automatic logic [SEL_W:0] resolve(
        input logic [REG_AW-1:0]             r,
        input logic                          used,
        input logic [NSTG-1:0]               v,
        input logic [NSTG-1:0]               we,
        input logic [NSTG-1:0]               ld,
        input logic [NSTG-1:0][REG_AW-1:0]   rd
    );
        logic [SEL_W-1:0] sel;
        logic             haz;
        sel = FWD_GR;
        haz = 1'b0;
        for (int i = int'(NSTG) - 1; i >= 0; i--) begin
            if (used && (r != '0) && v[i] && we[i] && (rd[i] == r)) begin
                sel = FWD_GR;
                haz = 1'b0;
                case (i)
                    0:       if (ld[i]) haz = 1'b1; else sel = FWD_EX;
                    1:       if (ld[i]) haz = 1'b1; else sel = FWD_MM1;
                    2:       sel = ld[i] ? FWD_MM2_MEM : FWD_MM2_REG;
                    default: sel = FWD_WB;
                endcase
            end
        end
        return {haz, sel};
    endfunction

    // Flatten the shadow pipeline for the resolver.
    always_comb begin
        for (int i = 0; i < int'(NSTG); i++) begin
            v_vec[i]  = stg_q[i].v;
            we_vec[i] = stg_q[i].we;
            ld_vec[i] = stg_q[i].ld;
            rd_vec[i] = stg_q[i].rd;
        end
    end

    assign res_rj   = resolve(id_rj, id_rj_used, v_vec, we_vec, ld_vec, rd_vec);
    assign res_rk   = resolve(id_rk, id_rk_used, v_vec, we_vec, ld_vec, rd_vec);
    assign fwd_rj   = res_rj[SEL_W-1:0];
    assign fwd_rk   = res_rk[SEL_W-1:0];
    assign id_stall = id_valid & (res_rj[SEL_W] | res_rk[SEL_W]);

    // A stalled ID inserts a bubble instead of entering EX.
    assign cap = id_adv & id_valid & ~id_stall;

    // Shadow pipeline next state: load beats advance-out, else clear, else hold.
    always_comb begin
        for (int i = 0; i < int'(NSTG); i++) begin
            stg_d[i] = stg_q[i];
        end
        if (cap) begin
            stg_d[0] = '{v: 1'b1, rd: id_rd, we: id_gr_we, ld: id_is_load};
        end else if (adv[0]) begin
            stg_d[0].v = 1'b0;
        end
        for (int i = 1; i < int'(NSTG); i++) begin
            if (adv[i-1] && stg_q[i-1].v) begin
                stg_d[i] = stg_q[i-1];
            end else if (adv[i]) begin
                stg_d[i].v = 1'b0;
            end
        end
    end

    // Shadow pipeline registers; reset and flush both empty every stage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NSTG); i++) begin
            if (reset || flush) begin
                stg_q[i] <= '0;
            end else begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl_gen.sv
// Bench for fwd_ctrl_gen: hand-derived vector table, corner sequences for
// flush/reset with a full pipeline, then random traffic against a reference
// model of the instruction pipeline.
module tb_fwd_ctrl_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rj, id_rk, id_rd;
    logic       id_rj_used, id_rk_used, id_gr_we, id_is_load;
    logic       id_adv, ex_adv, mm1_adv, mm2_adv, wb_adv, flush;
    logic [2:0] fwd_rj, fwd_rk;
    logic       id_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, fl, val;
        logic [4:0] rj;  logic uj;
        logic [4:0] rk;  logic uk;
        logic [4:0] rd;  logic we, ld;
        logic [4:0] adv;              // {id, ex, mm1, mm2, wb}
        logic [2:0] ej, ek;
        logic       es;
    } vec_t;

    // Reference model: one slot per pipeline stage holding the instruction's
    // destination info (0 = EX, 1 = MM1, 2 = MM2, 3 = WB).
    bit       m_v [4];
    bit [4:0] m_rd [4];
    bit       m_we [4];
    bit       m_ld [4];

    fwd_ctrl_gen dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rj(id_rj), .id_rk(id_rk), .id_rj_used(id_rj_used), .id_rk_used(id_rk_used),
        .id_rd(id_rd), .id_gr_we(id_gr_we), .id_is_load(id_is_load),
        .id_adv(id_adv), .ex_adv(ex_adv), .mm1_adv(mm1_adv), .mm2_adv(mm2_adv),
        .wb_adv(wb_adv), .flush(flush),
        .fwd_rj(fwd_rj), .fwd_rk(fwd_rk), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input int rst, input int fl, input int val,
                                 input int rj, input int uj, input int rk, input int uk,
                                 input int rd, input int we, input int ld,
                                 input logic [4:0] adv,
                                 input int ej, input int ek, input int es);
        vec_t t;
        t.rst = (rst != 0); t.fl = (fl != 0); t.val = (val != 0);
        t.rj = 5'(rj); t.uj = (uj != 0); t.rk = 5'(rk); t.uk = (uk != 0);
        t.rd = 5'(rd); t.we = (we != 0); t.ld = (ld != 0);
        t.adv = adv;
        t.ej = 3'(ej); t.ek = 3'(ek); t.es = (es != 0);
        return t;
    endfunction

    // Find the newest in-flight writer of r and decide where its value lives.
    function automatic void m_sel(input bit [4:0] r, input bit used,
                                  output bit [2:0] s, output bit haz);
        s = 3'd0;
        haz = 1'b0;
        if (!used || r == 5'd0) return;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i] && m_we[i] && m_rd[i] == r) begin
                if (i < 2 && m_ld[i]) haz = 1'b1;
                else if (i == 0) s = 3'd1;
                else if (i == 1) s = 3'd2;
                else if (i == 2) s = m_ld[i] ? 3'd4 : 3'd3;
                else s = 3'd5;
                return;
            end
        end
    endfunction

    // Move instructions through the model at a clock edge, oldest first.
    function automatic void m_clock(input vec_t t, input bit stall);
        bit a [4];
        a[0] = t.adv[3]; a[1] = t.adv[2]; a[2] = t.adv[1]; a[3] = t.adv[0];
        if (t.rst || t.fl) begin
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
            return;
        end
        for (int i = 3; i >= 1; i--) begin
            if (a[i-1] && m_v[i-1]) begin
                m_v[i] = 1'b1; m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
            end else if (a[i]) begin
                m_v[i] = 1'b0;
            end
        end
        if (t.adv[4] && t.val && !stall) begin
            m_v[0] = 1'b1; m_rd[0] = t.rd; m_we[0] = t.we; m_ld[0] = t.ld;
        end else if (a[0]) begin
            m_v[0] = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // mode 0: no check, 1: check against vector, 2: check against model.
    task automatic step(input vec_t t, input int mode, input string tag);
        bit [2:0] sj, sk;
        bit       hj, hk, ms;
        int       ej, ek, es;
        @(negedge clk);
        reset = t.rst; flush = t.fl; id_valid = t.val;
        id_rj = t.rj; id_rj_used = t.uj; id_rk = t.rk; id_rk_used = t.uk;
        id_rd = t.rd; id_gr_we = t.we; id_is_load = t.ld;
        {id_adv, ex_adv, mm1_adv, mm2_adv, wb_adv} = t.adv;
        #1;
        m_sel(t.rj, t.uj, sj, hj);
        m_sel(t.rk, t.uk, sk, hk);
        ms = t.val && (hj || hk);
        if (mode == 1) begin
            ej = int'(t.ej); ek = int'(t.ek); es = int'(t.es);
        end else begin
            ej = int'(sj); ek = int'(sk); es = int'(ms);
        end
        if (mode != 0) begin
            check({tag, " fwd_rj"}, int'(fwd_rj), ej);
            check({tag, " fwd_rk"}, int'(fwd_rk), ek);
            check({tag, " id_stall"}, int'(id_stall), es);
        end
        @(posedge clk);
        m_clock(t, ms);
    endtask

    // Fill all four stages with ALU writers r1..r4, then clear via flush or reset.
    task automatic fill_and_clear(input bit use_reset);
        string tag;
        tag = use_reset ? "rst_seq" : "flush_seq";
        step(mkv(0,1,0, 0,0,0,0, 0,0,0, 5'b00000, 0,0,0), 1, tag);
        step(mkv(0,0,1, 0,0,0,0, 1,1,0, 5'b10000, 0,0,0), 1, tag);
        step(mkv(0,0,1, 0,0,0,0, 2,1,0, 5'b11000, 0,0,0), 1, tag);
        step(mkv(0,0,1, 0,0,0,0, 3,1,0, 5'b11100, 0,0,0), 1, tag);
        step(mkv(0,0,1, 0,0,0,0, 4,1,0, 5'b11110, 0,0,0), 1, tag);
        step(mkv(0,0,1, 1,1,2,1, 0,0,0, 5'b00000, 5,3,0), 1, tag);
        step(mkv(0,0,1, 3,1,4,1, 0,0,0, 5'b00000, 2,1,0), 1, tag);
        // Clear with a capture and every advance active in the same cycle.
        step(mkv(use_reset ? 1 : 0, use_reset ? 0 : 1, 1, 1,1,4,1, 9,1,1,
                 5'b11111, 5,1,0), 1, tag);
        step(mkv(0,0,1, 9,1,4,1, 0,0,0, 5'b00000, 0,0,0), 1, tag);
        step(mkv(0,0,1, 2,1,3,1, 0,0,0, 5'b00000, 0,0,0), 1, tag);
        step(mkv(0,0,1, 1,1,1,1, 0,0,0, 5'b00000, 0,0,0), 1, tag);
    endtask

    vec_t tbl[$];

    initial begin
        // Forwarding chain for an ALU writer of r5.
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 5,1,0, 5'b10000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b00000, 1,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b01000, 1,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b00100, 2,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b00010, 3,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b00001, 5,0,0));
        tbl.push_back(mkv(0,0,1, 5,1,0,0, 0,0,0, 5'b00000, 0,0,0));
        // Load-use on r7; the stalled instruction (rd=9) must never enter EX.
        tbl.push_back(mkv(0,0,1, 0,0,7,1, 7,1,1, 5'b10000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 0,0,7,1, 9,1,0, 5'b10000, 0,0,1));
        tbl.push_back(mkv(0,0,1, 0,0,7,1, 9,1,0, 5'b11000, 0,0,1));
        tbl.push_back(mkv(0,0,1, 0,0,7,1, 9,1,0, 5'b10000, 0,0,1));
        tbl.push_back(mkv(0,0,1, 0,0,7,1, 9,1,0, 5'b10100, 0,0,1));
        tbl.push_back(mkv(0,0,1, 9,1,7,1, 0,0,0, 5'b00000, 0,4,0));
        tbl.push_back(mkv(0,1,0, 0,0,0,0, 0,0,0, 5'b00000, 0,0,0));
        // Youngest writer wins; younger load masks older ALU result.
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 3,1,0, 5'b10000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 0,0,0, 5'b01000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 3,1,0, 5'b10100, 0,0,0));
        tbl.push_back(mkv(0,0,1, 3,1,0,0, 0,0,0, 5'b00000, 1,0,0));
        tbl.push_back(mkv(0,0,1, 3,1,0,0, 3,1,1, 5'b11000, 1,0,0));
        tbl.push_back(mkv(0,0,1, 3,1,3,1, 0,0,0, 5'b00000, 0,0,1));
        tbl.push_back(mkv(0,1,1, 0,0,0,0, 0,0,0, 5'b00000, 0,0,0));
        // r0 writer, unused operand, non-writing producer.
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 0,1,0, 5'b10000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 0,1,0,1, 0,0,0, 5'b00000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 4,1,0, 5'b11000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 4,0,4,1, 0,0,0, 5'b00000, 0,1,0));
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 6,0,0, 5'b11000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 6,1,4,1, 0,0,0, 5'b00000, 0,2,0));
        // Load hazard with an invalid ID: no stall, no capture.
        tbl.push_back(mkv(0,0,1, 0,0,0,0, 8,1,1, 5'b11000, 0,0,0));
        tbl.push_back(mkv(0,0,0, 8,1,0,0, 0,0,0, 5'b00000, 0,0,0));
        tbl.push_back(mkv(0,0,0, 8,1,0,0, 10,1,0, 5'b10000, 0,0,0));
        tbl.push_back(mkv(0,0,1, 10,1,8,1, 0,0,0, 5'b00000, 0,0,1));

        step(mkv(1,0,0, 0,0,0,0, 0,0,0, 5'b00000, 0,0,0), 0, "reset");
        step(mkv(1,0,0, 0,0,0,0, 0,0,0, 5'b00000, 0,0,0), 0, "reset");

        foreach (tbl[i]) step(tbl[i], 1, $sformatf("vec%0d", i));

        fill_and_clear(1'b0);
        fill_and_clear(1'b1);

        for (int n = 0; n < 800; n++) begin
            vec_t t;
            t.rst = ($urandom_range(63) == 0);
            t.fl  = ($urandom_range(15) == 0);
            t.val = ($urandom_range(3) != 0);
            t.rj  = 5'($urandom_range(7));
            t.rk  = 5'($urandom_range(7));
            t.uj  = ($urandom_range(3) != 0);
            t.uk  = ($urandom_range(3) != 0);
            t.rd  = 5'($urandom_range(7));
            t.we  = ($urandom_range(3) != 0);
            t.ld  = ($urandom_range(2) == 0);
            t.adv = 5'($urandom_range(31));
            t.ej = 3'd0; t.ek = 3'd0; t.es = 1'b0;
            step(t, 2, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
